cpu_prog_loader: RTL and testbench

//  Write-side front end for the 4-bit accumulator CPU: accepts a byte stream over a valid/ready

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_prog_loader.sv | 170 +++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU and its program loader.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XNOR = 4'b0111
    } opcode_e;

    localparam logic [3:0] CMD_WR_IMEM = 4'h1;
    localparam logic [3:0] CMD_WR_DMEM = 4'h2;
    localparam logic [3:0] CMD_RUN     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CNT  = 2'd1,
        ST_DATA = 2'd2,
        ST_LAST = 2'd3
    } ld_state_e;

    function automatic logic is_wr_cmd(input logic [3:0] cmd);
        return (cmd == CMD_WR_IMEM) || (cmd == CMD_WR_DMEM);
    endfunction

endpackage

// File: rtl/cpu_prog_loader.sv
// Byte-stream loader: parses HDR/CNT/DATA packets into instruction/data memory
// writes and controls the CPU reset hold.
module cpu_prog_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              err
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rem_q, rem_d;
    logic              tgt_dmem_q, tgt_dmem_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              xfer_s;
    logic [3:0]        cmd_s;
    logic [4:0]        cnt_s;
    logic              cnt_ok_s;

    assign xfer_s   = in_valid & in_ready_q;
    assign cmd_s    = in_data[7:4];
    assign cnt_s    = in_data[4:0];
    assign cnt_ok_s = (cnt_s != 5'd0) && (cnt_s <= 5'd16);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && is_wr_cmd(cmd_s)) state_d = ST_CNT;
                else                            state_d = ST_IDLE;
            end
            ST_CNT: begin
                if (xfer_s) state_d = cnt_ok_s ? ST_DATA : ST_IDLE;
                else        state_d = ST_CNT;
            end
            ST_DATA: begin
                if (xfer_s && (rem_q == 5'd1)) state_d = ST_LAST;
                else                           state_d = ST_DATA;
            end
            ST_LAST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; in_ready/busy follow the upcoming state
    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        tgt_dmem_d  = tgt_dmem_q;
        hold_d      = hold_q;
        err_d       = err_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        in_ready_d  = (state_d != ST_LAST);
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (is_wr_cmd(cmd_s)) begin
                        tgt_dmem_d = (cmd_s == CMD_WR_DMEM);
                        addr_d     = in_data[ADDR_W-1:0];
                        hold_d     = 1'b1;
                    end else if (cmd_s == CMD_RUN) begin
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            ST_CNT: begin
                if (xfer_s && !cnt_ok_s) begin
                    err_d = 1'b1;
                end else if (xfer_s) begin
                    rem_d = cnt_s;
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    imem_we_d   = ~tgt_dmem_q;
                    dmem_we_d   = tgt_dmem_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data[DATA_W-1:0];
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_d       = rem_q - 5'd1;
                end else begin
                    addr_d = addr_q;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            rem_q       <= 5'd0;
            tgt_dmem_q  <= 1'b0;
            hold_q      <= 1'b1;
            err_q       <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            tgt_dmem_q  <= tgt_dmem_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = hold_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Bench for cpu_prog_loader: packet-level reference model compared every cycle,
// plus directed packets with literal expectations on the resulting memory writes.
module tb_cpu_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, imem_we, dmem_we, cpu_hold, busy, err;
    logic [3:0] mem_addr, mem_wdata;

    cpu_prog_loader #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .dmem_we(dmem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: interprets accepted bytes by their position in the packet.
    logic       m_ready, m_hold, m_busy, m_err, m_imem, m_dmem;
    logic [3:0] m_addr_o, m_wdata_o, m_waddr;
    logic       m_to_dmem, m_last, m_fresh;
    int         m_idx, m_left;

    always @(posedge clk or negedge reset) begin
        logic [7:0] b;
        if (!reset) begin
            m_ready = 1'b0; m_hold = 1'b1; m_busy = 1'b0; m_err = 1'b0;
            m_imem = 1'b0; m_dmem = 1'b0; m_addr_o = 4'd0; m_wdata_o = 4'd0;
            m_waddr = 4'd0; m_to_dmem = 1'b0; m_last = 1'b0; m_fresh = 1'b1;
            m_idx = 0; m_left = 0;
        end else begin
            m_imem = 1'b0;
            m_dmem = 1'b0;
            if (m_fresh) begin
                m_fresh = 1'b0;
                m_ready = 1'b1;
            end else if (m_last) begin
                m_last  = 1'b0;
                m_ready = 1'b1;
                m_busy  = 1'b0;
            end else if (in_valid && m_ready) begin
                b = in_data;
                if (m_idx == 0) begin
                    if (b[7:4] == 4'h1 || b[7:4] == 4'h2) begin
                        m_to_dmem = (b[7:4] == 4'h2);
                        m_waddr   = b[3:0];
                        m_hold    = 1'b1;
                        m_busy    = 1'b1;
                        m_idx     = 1;
                    end else if (b[7:4] == 4'hF) begin
                        m_hold = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (m_idx == 1) begin
                    if (b[4:0] == 5'd0 || int'(b[4:0]) > 16) begin
                        m_err  = 1'b1;
                        m_busy = 1'b0;
                        m_idx  = 0;
                    end else begin
                        m_left = int'(b[4:0]);
                        m_idx  = 2;
                    end
                end else begin
                    m_imem    = ~m_to_dmem;
                    m_dmem    = m_to_dmem;
                    m_addr_o  = m_waddr;
                    m_wdata_o = b[3:0];
                    m_waddr   = 4'((int'(m_waddr) + 1) % 16);
                    m_left    = m_left - 1;
                    if (m_left == 0) begin
                        m_idx   = 0;
                        m_last  = 1'b1;
                        m_ready = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
            chk("imem_we",   {31'd0, imem_we},   {31'd0, m_imem});
            chk("dmem_we",   {31'd0, dmem_we},   {31'd0, m_dmem});
            chk("mem_addr",  {28'd0, mem_addr},  {28'd0, m_addr_o});
            chk("mem_wdata", {28'd0, mem_wdata}, {28'd0, m_wdata_o});
            chk("cpu_hold",  {31'd0, cpu_hold},  {31'd0, m_hold});
            chk("busy",      {31'd0, busy},      {31'd0, m_busy});
            chk("err",       {31'd0, err},       {31'd0, m_err});
        end
    end

    // Memory images and write log built from the DUT strobes
    logic [3:0]  tb_imem [16];
    logic [3:0]  tb_dmem [16];
    logic [9:0]  wlog [$];
    logic [9:0]  ref_log [$];

    always @(posedge clk) begin
        if (reset) begin
            if (imem_we) begin
                tb_imem[mem_addr] = mem_wdata;
                wlog.push_back({imem_we, dmem_we, mem_addr, mem_wdata});
            end
            if (dmem_we) begin
                tb_dmem[mem_addr] = mem_wdata;
                wlog.push_back({imem_we, dmem_we, mem_addr, mem_wdata});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 64 cycles", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
    endtask

    logic [7:0] s2 [14] = '{8'h10, 8'h0C, 8'h01, 8'h03, 8'h02, 8'h00, 8'h05,
                            8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h07, 8'h00};
    logic [3:0] prog [12] = '{4'h1, 4'h3, 4'h2, 4'h0, 4'h5, 4'h0,
                              4'h3, 4'h0, 4'h4, 4'h0, 4'h7, 4'h0};
    logic [7:0] s7 [4] = '{8'h09, 8'h08, 8'h07, 8'h06};

    initial begin
        // 1. reset values and idle after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_err",      {31'd0, err},      32'd0);
        chk("rst_imem_we",  {31'd0, imem_we},  32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        reset = 1'b1;
        idle(3);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("idle_no_strobe", wlog.size(), 32'd0);

        // 2. 12-word program load
        for (int i = 0; i < 14; i++) send(s2[i]);
        idle(3);
        chk("t2_writes", wlog.size(), 32'd12);
        for (int i = 0; i < 12; i++) chk("t2_imem", {28'd0, tb_imem[i]}, {28'd0, prog[i]});
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // 3. data load then RUN
        send(8'h20); send(8'h02); send(8'h04); send(8'h02);
        chk("t3_hold_pre", {31'd0, cpu_hold}, 32'd1);
        send(8'hF0);
        chk("t3_hold_run", {31'd0, cpu_hold}, 32'd0);
        idle(2);
        chk("t3_dmem0", {28'd0, tb_dmem[0]}, 32'd4);
        chk("t3_dmem1", {28'd0, tb_dmem[1]}, 32'd2);
        send(8'hF3);
        idle(1);
        chk("t3_rerun_err", {31'd0, err}, 32'd0);

        // 4. address wrap; header re-asserts hold
        wlog.delete();
        send(8'h1E);
        chk("t4_hold_back", {31'd0, cpu_hold}, 32'd1);
        send(8'h03); send(8'h5A); send(8'h6B); send(8'h0C);
        idle(3);
        chk("t4_n", wlog.size(), 32'd3);
        if (wlog.size() == 3) begin
            chk("t4_w0", {22'd0, wlog[0]}, {22'd0, 2'b10, 4'd14, 4'hA});
            chk("t4_w1", {22'd0, wlog[1]}, {22'd0, 2'b10, 4'd15, 4'hB});
            chk("t4_w2", {22'd0, wlog[2]}, {22'd0, 2'b10, 4'd0,  4'hC});
        end

        // 5. protocol errors, each followed by a good packet
        do_reset();
        wlog.delete();
        send(8'h70);
        idle(2);
        chk("t5_badcmd_err", {31'd0, err}, 32'd1);
        chk("t5_badcmd_nowr", wlog.size(), 32'd0);
        send(8'h21); send(8'h01); send(8'h3A);
        idle(3);
        chk("t5_dmem1", {28'd0, tb_dmem[1]}, 32'hA);

        do_reset();
        send(8'h10); send(8'h00);
        idle(1);
        chk("t5_n0_err", {31'd0, err}, 32'd1);
        chk("t5_n0_busy", {31'd0, busy}, 32'd0);
        send(8'h14); send(8'hE2); send(8'h07); send(8'h08);
        idle(3);
        chk("t5_imem4", {28'd0, tb_imem[4]}, 32'h7);
        chk("t5_imem5", {28'd0, tb_imem[5]}, 32'h8);

        do_reset();
        send(8'h10); send(8'h11);
        idle(1);
        chk("t5_n17_err", {31'd0, err}, 32'd1);
        wlog.delete();
        send(8'h18); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(15 - i));
        idle(3);
        chk("t5_n16_writes", wlog.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            chk("t5_n16_imem", {28'd0, tb_imem[(i + 8) % 16]}, 32'(15 - i));

        // 6. reset in the middle of DATA
        do_reset();
        send(8'h10); send(8'h05); send(8'h01); send(8'h02);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_imem_we", {31'd0, imem_we}, 32'd0);
        chk("t6_addr",    {28'd0, mem_addr}, 32'd0);
        chk("t6_wdata",   {28'd0, mem_wdata}, 32'd0);
        chk("t6_busy",    {31'd0, busy}, 32'd0);
        chk("t6_ready",   {31'd0, in_ready}, 32'd0);
        chk("t6_hold",    {31'd0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        wlog.delete();
        send(8'h18); send(8'h02); send(8'h09); send(8'h0A);
        idle(3);
        chk("t6_n", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("t6_w0", {22'd0, wlog[0]}, {22'd0, 2'b10, 4'd8, 4'h9});
            chk("t6_w1", {22'd0, wlog[1]}, {22'd0, 2'b10, 4'd9, 4'hA});
        end

        // 7. gaps in in_valid do not change the write sequence
        do_reset();
        wlog.delete();
        send(8'h23); send(8'h04);
        for (int i = 0; i < 4; i++) send(s7[i]);
        idle(3);
        ref_log = wlog;
        chk("t7_ref_n", ref_log.size(), 32'd4);
        if (ref_log.size() == 4) begin
            chk("t7_ref0", {22'd0, ref_log[0]}, {22'd0, 2'b01, 4'd3, 4'h9});
            chk("t7_ref3", {22'd0, ref_log[3]}, {22'd0, 2'b01, 4'd6, 4'h6});
        end
        wlog.delete();
        send(8'h23);
        idle($urandom_range(0, 3));
        send(8'h04);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(1, 4));
            send(s7[i]);
        end
        idle(3);
        chk("t7_gap_n", wlog.size(), ref_log.size());
        for (int i = 0; i < 4; i++)
            if (i < wlog.size() && i < ref_log.size())
                chk("t7_gap_w", {22'd0, wlog[i]}, {22'd0, ref_log[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
